// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Control sequencer for an iterative multiply/divide unit.
//                Accepts mult/multu/div/divu from EX, steps the datapath a
//                fixed number of iterations, pulses the HI/LO write, and
//                stalls dependent ID instructions while the unit is busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 4,   // multiply iterations, 1..63
    parameter int DIV_CYCLES = 32   // divide iterations, 1..63
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active low
    input  logic       startE,
    input  logic [1:0] opE,
    input  logic       divisorZeroE,
    input  logic       flushE,
    input  logic       mulDivD,
    input  logic       hiloReadD,
    output logic       dpStart,
    output logic       dpStep,
    output logic       hiloWrite,
    output logic       divZero,
    output logic       busy,
    output logic       Stall
);

    // Iteration counter reload values: the counter runs N-1 down to 0,
    // giving exactly N BUSY cycles.
    localparam logic [5:0] c_MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] c_DIV_LOAD = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [5:0] r_cnt;
    logic [5:0] w_cntNext;
    logic       r_divZero;
    logic       w_divZeroNext;
    logic       w_accept;
    logic       w_isDiv;

    assign w_isDiv = opE[1];

    // State, iteration counter and divide-by-zero flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_divZero <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_divZero <= w_divZeroNext;
        end
    end

    // Next-state and output decode. A flushed EX instruction is never
    // accepted; once an operation is in flight it always runs to completion.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_divZeroNext = r_divZero;
        w_accept      = 1'b0;
        dpStart       = 1'b0;
        dpStep        = 1'b0;
        hiloWrite     = 1'b0;
        divZero       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_accept = startE && !flushE;
                dpStart  = w_accept;
                if (w_accept) begin
                    if (w_isDiv && divisorZeroE) begin
                        // Divide by zero: skip iterations, report next cycle.
                        w_stateNext   = S_DONE;
                        w_divZeroNext = 1'b1;
                    end else begin
                        w_stateNext   = S_BUSY;
                        w_cntNext     = w_isDiv ? c_DIV_LOAD : c_MUL_LOAD;
                        w_divZeroNext = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                dpStep = 1'b1;
                if (r_cnt == 6'd0) begin
                    w_stateNext = S_DONE;
                end else begin
                    w_cntNext = r_cnt - 6'd1;
                end
            end
            S_DONE: begin
                hiloWrite   = 1'b1;
                divZero     = r_divZero;
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Busy covers BUSY and DONE; ID consumers of HI/LO or the unit itself
    // must wait, including in the accept cycle before busy rises.
    always_comb begin
        busy  = (r_state != S_IDLE);
        Stall = (busy || w_accept) && (mulDivD || hiloReadD);
    end

    // Datapath control strobes never overlap.
    a_strobeExclusive : assert property (
        @(posedge clk) disable iff (!rst)
        $onehot0({dpStart, dpStep, hiloWrite})
    );

    // The result write lasts exactly one cycle.
    a_doneSingleCycle : assert property (
        @(posedge clk) disable iff (!rst)
        (r_state == S_DONE) |=> (r_state == S_IDLE)
    );

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer. A latency-based
//                reference model tracks the pending operation; directed
//                scenarios pin absolute cycle timings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int MULN = 4;
    localparam int DIVN = 32;

    logic       clk;
    logic       rst;
    logic       startE;
    logic [1:0] opE;
    logic       divisorZeroE;
    logic       flushE;
    logic       mulDivD;
    logic       hiloReadD;
    logic       dpStart;
    logic       dpStep;
    logic       hiloWrite;
    logic       divZero;
    logic       busy;
    logic       Stall;

    int compared = 0;
    int failed   = 0;

    muldiv_sequencer #(
        .MUL_CYCLES(MULN),
        .DIV_CYCLES(DIVN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .startE      (startE),
        .opE         (opE),
        .divisorZeroE(divisorZeroE),
        .flushE      (flushE),
        .mulDivD     (mulDivD),
        .hiloReadD   (hiloReadD),
        .dpStart     (dpStart),
        .dpStep      (dpStep),
        .hiloWrite   (hiloWrite),
        .divZero     (divZero),
        .busy        (busy),
        .Stall       (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mBusy: an operation is pending; mRemain: cycles left before the
    // hiloWrite cycle; mDz: the pending operation is a divide by zero.
    logic mBusy   = 1'b0;
    int   mRemain = 0;
    logic mDz     = 1'b0;

    always @(negedge clk) begin
        logic eAccept, eDone, eStep;
        if (!rst) begin
            mBusy   = 1'b0;
            mRemain = 0;
            mDz     = 1'b0;
        end
        eAccept = !mBusy && startE && !flushE;
        eDone   = mBusy && (mRemain == 0);
        eStep   = mBusy && (mRemain != 0);
        check("m_dpStart",   dpStart,   eAccept);
        check("m_dpStep",    dpStep,    eStep);
        check("m_hiloWrite", hiloWrite, eDone);
        check("m_busy",      busy,      mBusy);
        check("m_Stall",     Stall,     (mBusy || eAccept) && (mulDivD || hiloReadD));
        if (eDone)
            check("m_divZero", divZero, mDz);
        if (!rst)
            check("m_divZeroRst", divZero, 1'b0);
        if (rst) begin
            if (eAccept) begin
                mBusy   = 1'b1;
                mDz     = opE[1] && divisorZeroE;
                mRemain = mDz ? 0 : (opE[1] ? DIVN : MULN);
            end else if (mBusy) begin
                if (mRemain == 0) mBusy = 1'b0;
                else              mRemain = mRemain - 1;
            end
        end
    end

    // ---------------- stimulus and directed checks ----------------
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; startE = 1'b0; opE = 2'b00; divisorZeroE = 1'b0;
        flushE = 1'b0; mulDivD = 1'b0; hiloReadD = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_hiloWrite", hiloWrite, 1'b0);
        repeat (2) nextCycle();
        rst = 1'b1;
        nextCycle();

        // mult with default iterations
        startE = 1'b1; opE = 2'b00;
        @(negedge clk);
        check("d1_dpStart_c0", dpStart, 1'b1);
        nextCycle();
        startE = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("d1_dpStep", dpStep, c <= 4);
            check("d1_hiloWrite", hiloWrite, c == 5);
            check("d1_busy", busy, 1'b1);
            if (c == 5) check("d1_divZero", divZero, 1'b0);
            nextCycle();
        end

        // divu by zero
        startE = 1'b1; opE = 2'b11; divisorZeroE = 1'b1;
        @(negedge clk);
        check("d2_dpStart_c0", dpStart, 1'b1);
        nextCycle();
        startE = 1'b0; divisorZeroE = 1'b0;
        @(negedge clk);
        check("d2_hiloWrite_c1", hiloWrite, 1'b1);
        check("d2_divZero_c1", divZero, 1'b1);
        check("d2_dpStep_c1", dpStep, 1'b0);
        nextCycle();

        // div with mfhi waiting in ID
        startE = 1'b1; opE = 2'b10;
        nextCycle();
        startE = 1'b0; hiloReadD = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            check("d3_Stall", Stall, c <= 33);
            check("d3_hiloWrite", hiloWrite, c == 33);
            nextCycle();
        end
        hiloReadD = 1'b0;

        // start with flush in IDLE
        startE = 1'b1; flushE = 1'b1; opE = 2'b00;
        @(negedge clk);
        check("d4_dpStart", dpStart, 1'b0);
        nextCycle();
        startE = 1'b0; flushE = 1'b0;
        @(negedge clk);
        check("d4_busy", busy, 1'b0);
        check("d4_hiloWrite", hiloWrite, 1'b0);
        nextCycle();

        // reset mid-divide with 10 iterations left on the counter
        startE = 1'b1; opE = 2'b10;
        nextCycle();
        startE = 1'b0;
        for (int c = 1; c < 22; c++) nextCycle();
        rst = 1'b0;
        #1;
        check("d5_busyAsync", busy, 1'b0);
        check("d5_dpStepAsync", dpStep, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("d5_hiloWriteRst", hiloWrite, 1'b0);
            nextCycle();
        end
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("d5_noHiloWrite", hiloWrite, 1'b0);
            nextCycle();
        end
        startE = 1'b1; opE = 2'b00;
        nextCycle();
        startE = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("d5_multAfter", hiloWrite, c == 5);
            nextCycle();
        end

        // back-to-back: startE held through the mult, div accepted at cycle 6
        for (int c = 0; c <= 39; c++) begin
            startE = (c <= 6);
            opE    = (c == 0) ? 2'b00 : 2'b10;
            @(negedge clk);
            check("d6_dpStart", dpStart, (c == 0) || (c == 6));
            check("d6_hiloWrite", hiloWrite, (c == 5) || (c == 39));
            nextCycle();
        end
        startE = 1'b0;
        nextCycle();

        // randomized traffic, occasional reset pulses
        for (int i = 0; i < 4000; i++) begin
            startE       = ($urandom_range(0, 2) != 0);
            opE          = 2'($urandom_range(0, 3));
            divisorZeroE = ($urandom_range(0, 5) == 0);
            flushE       = ($urandom_range(0, 6) == 0);
            mulDivD      = ($urandom_range(0, 3) == 0);
            hiloReadD    = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 249) != 0);
            nextCycle();
        end
        rst = 1'b1; startE = 1'b0;
        repeat (2) nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning the number of multiply iteration cycles (legal range 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning the number of divide iteration cycles (legal range 1..63).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port startE  input  1  mult/multu/div/divu instruction present in EX this cycle.
REQ-006 SHALL have port opE  input  2  EX operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port divisorZeroE  input  1  EX divisor operand equals zero.
REQ-008 SHALL have port flushE  input  1  EX instruction is being flushed this cycle.
REQ-009 SHALL have port mulDivD  input  1  mult/div-class instruction present in ID.
REQ-010 SHALL have port hiloReadD  input  1  mfhi/mflo present in ID.
REQ-011 SHALL have port dpStart  output  1  datapath loads operands and opE this cycle.
REQ-012 SHALL have port dpStep  output  1  datapath performs one iteration this cycle.
REQ-013 SHALL have port hiloWrite  output  1  HI/LO registers capture the result this cycle.
REQ-014 SHALL have port divZero  output  1  the completing operation was a divide by zero; valid only with hiloWrite.
REQ-015 SHALL have port busy  output  1  sequencer not IDLE.
REQ-016 SHALL have port Stall  output  1  freeze PC and IF/ID, bubble into EX.

Function
REQ-017 SHALL implement states IDLE, BUSY and DONE, plus a 6-bit down-counter cnt and a registered divZero flag.
REQ-018 SHALL define accept as IDLE and startE and not flushE.
REQ-019 SHALL drive dpStart = accept, combinationally.
REQ-020 SHALL, on accept with a divide op (opE[1]=1) and divisorZeroE=1, go IDLE->DONE and set the divZero flag to 1.
REQ-021 SHALL, on any other accept, go IDLE->BUSY, load cnt with MUL_CYCLES-1 for opE[1]=0 or DIV_CYCLES-1 for opE[1]=1, and clear the divZero flag.
REQ-022 SHALL assert dpStep in every BUSY cycle and only in BUSY cycles.
REQ-023 SHALL, in BUSY, decrement cnt each cycle while cnt is nonzero; when cnt=0, go BUSY->DONE.
REQ-024 SHALL assert hiloWrite for exactly the one DONE cycle, with divZero equal to the flag in that cycle, then go DONE->IDLE.
REQ-025 SHALL produce a latency from accept to the hiloWrite cycle of N+1 cycles for N iterations, and 1 cycle for a divide by zero.
REQ-026 SHALL drive busy = (state != IDLE).
REQ-027 SHALL drive Stall = (busy or accept) and (mulDivD or hiloReadD), combinationally.
REQ-028 SHALL NOT stall for ID instructions other than mulDivD or hiloReadD while busy; independent instructions proceed.
REQ-029 SHALL, when startE and flushE are both high in IDLE, not accept; dpStart=0, and state and outputs are unchanged.
REQ-030 SHALL ignore startE in BUSY and DONE, and SHALL ignore flushE in BUSY and DONE, so an in-flight operation always completes.
REQ-031 SHALL allow a new accept in the cycle immediately after DONE; back-to-back operations are separated by no idle gap beyond IDLE.
REQ-032 SHALL keep dpStart, dpStep and hiloWrite mutually exclusive in every cycle.

Reset
REQ-033 SHALL, while rst=0, force state to IDLE, cnt to 0 and the divZero flag to 0, so that dpStep=0, hiloWrite=0, divZero=0 and busy=0; dpStart and Stall then follow their combinational equations from the inputs.
REQ-034 SHALL, on reset asserted mid-operation, abandon the operation with no hiloWrite pulse; after release, the sequencer is in IDLE.

Verification
REQ-035 SHALL pass this scenario: mult accepted in cycle 0 with defaults -> dpStart in cycle 0, dpStep in cycles 1-4, hiloWrite in cycle 5, divZero=0, busy in cycles 1-5.
REQ-036 SHALL pass this scenario: divu with divisorZeroE=1 -> dpStart in cycle 0, hiloWrite and divZero=1 in cycle 1, no dpStep.
REQ-037 SHALL pass this scenario: div accepted, then mfhi held in ID from cycle 1 -> Stall=1 in cycles 1-33, Stall=0 in cycle 34, hiloWrite in cycle 33.
REQ-038 SHALL pass this scenario: startE=1 with flushE=1 in IDLE -> dpStart=0, busy stays 0, no hiloWrite.
REQ-039 SHALL pass this scenario: rst pulled low in BUSY with cnt=10 -> busy=0 immediately, no hiloWrite ever; a mult accepted after release completes normally.
REQ-040 SHALL pass this scenario: mult hiloWrite in cycle 5, new div accepted in cycle 6 -> dpStart in cycle 6, hiloWrite in cycle 39.
